// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/retire handshake bundle between the reorder buffer and its
// allocation controller. The master side is the dispatch stage plus the
// buffer's retire logic; the slave side is rob_alloc_ctrl.
interface rob_alloc_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  alloc_req0;
  logic                  alloc_req1;
  logic                  alloc_gnt0;
  logic                  alloc_gnt1;
  logic [ADDR_WIDTH-1:0] alloc_idx0;
  logic [ADDR_WIDTH-1:0] alloc_idx1;
  logic [ADDR_WIDTH-1:0] oldest0;
  logic [ADDR_WIDTH-1:0] oldest1;
  logic                  retire0;
  logic                  retire1;

  modport master (
    output alloc_req0, alloc_req1, retire0, retire1,
    input  alloc_gnt0, alloc_gnt1, alloc_idx0, alloc_idx1, oldest0, oldest1
  );

  modport slave (
    input  alloc_req0, alloc_req1, retire0, retire1,
    output alloc_gnt0, alloc_gnt1, alloc_idx0, alloc_idx1, oldest0, oldest1
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation/retirement controller.
// Hands out up to two slots per cycle in program order, tracks the oldest
// live slots for retirement, and sequences flush and drain.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal operation: grants and retires both allowed
// ST_DRAIN | allocation stopped, retires continue until drain_req drops
// ST_FLUSH | one-cycle buffer clear (rob_clear=1), no grants, no retires
module rob_alloc_ctrl #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  rob_alloc_ctrl_if.slave     rob,
  input  logic                flush,
  input  logic                drain_req,
  output logic                rob_clear,
  output logic                drained,
  output logic [ADDR_WIDTH:0] count,
  output logic                empty,
  output logic                full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_FULL_M1 = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE     = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rob_clear_q, rob_clear_d;

  logic       gnt0, gnt1;
  logic       ret0, ret1;
  logic [1:0] n_alloc, n_retire;

  // Grants and effective retires from registered state only; a retire in
  // this cycle never frees a slot for a grant in the same cycle.
  always_comb begin
    gnt0 = rob.alloc_req0 & (state_q == ST_RUN) & ~flush & ~reset &
           (count_q < CNT_FULL);
    gnt1 = rob.alloc_req1 & gnt0 & (count_q < CNT_FULL_M1);
    ret0 = rob.retire0 & (count_q != '0) & ~flush & (state_q != ST_FLUSH);
    ret1 = rob.retire1 & ret0 & (count_q > CNT_ONE);
    n_alloc  = {1'b0, gnt0} + {1'b0, gnt1};
    n_retire = {1'b0, ret0} + {1'b0, ret1};
  end

  // Next-state for pointers, occupancy, FSM and the clear strobe.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q + ADDR_WIDTH'(n_retire);
    tail_d      = tail_q + ADDR_WIDTH'(n_alloc);
    count_d     = count_q + (ADDR_WIDTH+1)'(n_alloc) - (ADDR_WIDTH+1)'(n_retire);
    rob_clear_d = 1'b0;
    if (flush) begin
      // Flush from any state, including FLUSH itself, restarts the clear.
      state_d     = ST_FLUSH;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      rob_clear_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN:   if (drain_req) state_d = ST_DRAIN;
        ST_DRAIN: if (!drain_req) state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Single registered FSM and datapath update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rob_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rob_clear_q <= rob_clear_d;
    end
  end

  assign rob.alloc_gnt0 = gnt0;
  assign rob.alloc_gnt1 = gnt1;
  assign rob.alloc_idx0 = tail_q;
  assign rob.alloc_idx1 = tail_q + 1'b1;
  assign rob.oldest0    = head_q;
  assign rob.oldest1    = head_q + 1'b1;

  assign rob_clear = rob_clear_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign drained   = (state_q == ST_DRAIN) & (count_q == '0);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Self-checking bench for rob_alloc_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_rob_alloc_ctrl;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_FLUSH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          drain_req;
  logic          rob_clear;
  logic          drained;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  always #5 clk = ~clk;

  rob_alloc_ctrl_if #(.ADDR_WIDTH(AW)) rif();

  rob_alloc_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rob       (rif),
    .flush     (flush),
    .drain_req (drain_req),
    .rob_clear (rob_clear),
    .drained   (drained),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  typedef struct {
    logic        g0, g1;
    logic [4:0]  idx0, idx1, old0, old1;
    logic [5:0]  cnt;
    logic        full, empty, clr, drained;
  } exp_t;

  typedef struct {
    logic q0, q1, t0, t1, fl, dr;
    exp_t e;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: ordered list of live slot indices plus next free index.
  int live[$];
  int m_tail;
  int m_mode;
  bit m_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".gnt0"},    rif.alloc_gnt0, e.g0);
    chk({tag, ".gnt1"},    rif.alloc_gnt1, e.g1);
    chk({tag, ".idx0"},    rif.alloc_idx0, e.idx0);
    chk({tag, ".idx1"},    rif.alloc_idx1, e.idx1);
    chk({tag, ".oldest0"}, rif.oldest0,    e.old0);
    chk({tag, ".oldest1"}, rif.oldest1,    e.old1);
    chk({tag, ".count"},   count,          e.cnt);
    chk({tag, ".full"},    full,           e.full);
    chk({tag, ".empty"},   empty,          e.empty);
    chk({tag, ".clear"},   rob_clear,      e.clr);
    chk({tag, ".drained"}, drained,        e.drained);
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   cnt;
    int   o0;
    cnt       = live.size();
    o0        = (cnt > 0) ? live[0] : m_tail;
    e.g0      = rif.alloc_req0 && (m_mode == M_RUN) && !flush && !reset && (cnt < DEPTH);
    e.g1      = rif.alloc_req1 && e.g0 && (cnt <= DEPTH - 2);
    e.idx0    = 5'(m_tail);
    e.idx1    = 5'((m_tail + 1) % DEPTH);
    e.old0    = 5'(o0);
    e.old1    = 5'((o0 + 1) % DEPTH);
    e.cnt     = 6'(cnt);
    e.full    = (cnt == DEPTH);
    e.empty   = (cnt == 0);
    e.clr     = m_clr;
    e.drained = (m_mode == M_DRAIN) && (cnt == 0);
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    int   cnt;
    bit   r0, r1;
    e   = model_expect();
    cnt = live.size();
    r0  = rif.retire0 && cnt >= 1 && !flush && m_mode != M_FLUSH;
    r1  = rif.retire1 && r0 && cnt >= 2;
    if (flush) begin
      live.delete();
      m_tail = 0;
      m_mode = M_FLUSH;
      m_clr  = 1'b1;
    end else begin
      if (r0) void'(live.pop_front());
      if (r1) void'(live.pop_front());
      if (e.g0) begin live.push_back(m_tail); m_tail = (m_tail + 1) % DEPTH; end
      if (e.g1) begin live.push_back(m_tail); m_tail = (m_tail + 1) % DEPTH; end
      case (m_mode)
        M_RUN:   if (drain_req) m_mode = M_DRAIN;
        M_DRAIN: if (!drain_req) m_mode = M_RUN;
        default: m_mode = M_RUN;
      endcase
      m_clr = 1'b0;
    end
  endtask

  task automatic drive(input bit q0, q1, t0, t1, fl, dr);
    @(negedge clk);
    rif.alloc_req0 = q0;
    rif.alloc_req1 = q1;
    rif.retire0    = t0;
    rif.retire1    = t1;
    flush          = fl;
    drain_req      = dr;
    #1;
  endtask

  task automatic cyc(input string tag, input bit q0, q1, t0, t1, fl, dr);
    drive(q0, q1, t0, t1, fl, dr);
    cmp(tag, model_expect());
    model_update();
  endtask

  task automatic do_reset(input bit fl_during);
    @(negedge clk);
    reset          = 1'b1;
    rif.alloc_req0 = 1'b1;
    rif.alloc_req1 = 1'b1;
    rif.retire0    = 1'b0;
    rif.retire1    = 1'b0;
    flush          = fl_during;
    drain_req      = fl_during;
    #1;
    chk("reset.gnt0", rif.alloc_gnt0, 0);
    chk("reset.gnt1", rif.alloc_gnt1, 0);
    @(negedge clk);
    reset          = 1'b0;
    rif.alloc_req0 = 1'b0;
    rif.alloc_req1 = 1'b0;
    flush          = 1'b0;
    drain_req      = 1'b0;
    live.delete();
    m_tail = 0;
    m_mode = M_RUN;
    m_clr  = 1'b0;
    #1;
    chk("reset.clear",   rob_clear,      0);
    chk("reset.count",   count,          0);
    chk("reset.idx1",    rif.alloc_idx1, 1);
    chk("reset.oldest1", rif.oldest1,    1);
    chk("reset.empty",   empty,          1);
    chk("reset.full",    full,           0);
    chk("reset.drained", drained,        0);
  endtask

  function automatic vec_t mk(input bit q0, q1, t0, t1, input bit g0, g1,
                              input int idx0, old0, cnt);
    vec_t v;
    v.q0 = q0; v.q1 = q1; v.t0 = t0; v.t1 = t1; v.fl = 1'b0; v.dr = 1'b0;
    v.e.g0      = g0;
    v.e.g1      = g1;
    v.e.idx0    = 5'(idx0);
    v.e.idx1    = 5'((idx0 + 1) % DEPTH);
    v.e.old0    = 5'(old0);
    v.e.old1    = 5'((old0 + 1) % DEPTH);
    v.e.cnt     = 6'(cnt);
    v.e.full    = (cnt == DEPTH);
    v.e.empty   = (cnt == 0);
    v.e.clr     = 1'b0;
    v.e.drained = 1'b0;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    bit q0, q1, t0, t1, fl, dr;
    int bias;

    // Directed table: fill to full, then boundary cases at DEPTH and DEPTH-1.
    for (int i = 0; i < 16; i++) tbl[i] = mk(1, 1, 0, 0, 1, 1, 2 * i, 0, 2 * i);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 0, 0, 32);
    tbl[17] = mk(1, 1, 1, 1, 0, 0, 0, 0, 32);
    tbl[18] = mk(1, 1, 0, 0, 1, 1, 0, 2, 30);
    tbl[19] = mk(0, 0, 1, 0, 0, 0, 2, 2, 32);
    tbl[20] = mk(1, 1, 0, 0, 1, 0, 2, 3, 31);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 3, 3, 32);

    reset = 1'b1;
    flush = 1'b0;
    drain_req = 1'b0;
    rif.alloc_req0 = 1'b0;
    rif.alloc_req1 = 1'b0;
    rif.retire0 = 1'b0;
    rif.retire1 = 1'b0;

    do_reset(1'b0);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].q0, tbl[i].q1, tbl[i].t0, tbl[i].t1, tbl[i].fl, tbl[i].dr);
      cmp($sformatf("vec%0d", i), tbl[i].e);
      model_update();
    end

    // Retire across the index wrap: head=30 with 4 live entries.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) cyc("wrap.fill", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc("wrap.ret", 0, 0, 1, 1, 0, 0);
    cyc("wrap.a0", 1, 1, 0, 0, 0, 0);
    chk("wrap.idx1_at30", rif.alloc_idx1, 31);
    cyc("wrap.a1", 1, 1, 0, 0, 0, 0);
    chk("wrap.idx0_at0", rif.alloc_idx0, 0);
    cyc("wrap.r0", 0, 0, 1, 1, 0, 0);
    chk("wrap.oldest0_30", rif.oldest0, 30);
    chk("wrap.oldest1_31", rif.oldest1, 31);
    cyc("wrap.r1", 0, 0, 1, 1, 0, 0);
    chk("wrap.oldest0_0", rif.oldest0, 0);
    cyc("wrap.r2", 0, 0, 1, 0, 0, 0);
    chk("wrap.oldest0_2", rif.oldest0, 2);
    chk("wrap.count0", count, 0);
    chk("wrap.empty", empty, 1);
    cyc("wrap.idle", 0, 0, 0, 0, 0, 0);
    chk("wrap.retire_empty_count", count, 0);
    chk("wrap.retire_empty_oldest", rif.oldest0, 2);

    // Drain with 10 live entries.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cyc("drain.fill", 1, 1, 0, 0, 0, 0);
    cyc("drain.enter", 0, 0, 0, 0, 0, 1);
    cyc("drain.blocked", 1, 0, 0, 0, 0, 1);
    chk("drain.gnt0_blocked", rif.alloc_gnt0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("drain.ret", 1, 0, 1, 0, 0, 1);
      chk("drain.not_yet", drained, 0);
    end
    cyc("drain.done", 0, 0, 0, 0, 0, 1);
    chk("drain.drained", drained, 1);
    cyc("drain.exit", 1, 0, 0, 0, 0, 0);
    chk("drain.exit_gnt0", rif.alloc_gnt0, 0);
    cyc("drain.run", 1, 0, 0, 0, 0, 0);
    chk("drain.run_gnt0", rif.alloc_gnt0, 1);
    chk("drain.run_drained", drained, 0);

    // Flush with 20 live entries and nonzero pointers.
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) cyc("flush.fill", 1, 1, 0, 0, 0, 0);
    cyc("flush.trim", 0, 0, 1, 1, 0, 0);
    cyc("flush.hit", 1, 0, 1, 0, 1, 0);
    chk("flush.gnt0", rif.alloc_gnt0, 0);
    cyc("flush.state", 1, 0, 0, 0, 0, 0);
    chk("flush.clear", rob_clear, 1);
    chk("flush.count", count, 0);
    chk("flush.head", rif.oldest0, 0);
    chk("flush.tail", rif.alloc_idx0, 0);
    chk("flush.no_gnt", rif.alloc_gnt0, 0);
    cyc("flush.after", 1, 0, 0, 0, 0, 0);
    chk("flush.after_clear", rob_clear, 0);
    chk("flush.after_gnt0", rif.alloc_gnt0, 1);
    chk("flush.after_idx0", rif.alloc_idx0, 0);

    // Back-to-back flush extends the clear; reset mid-flush cancels it.
    cyc("flush2.a", 0, 0, 0, 0, 1, 0);
    cyc("flush2.b", 0, 0, 0, 0, 1, 0);
    chk("flush2.clear_b", rob_clear, 1);
    cyc("flush2.c", 0, 0, 0, 0, 0, 0);
    chk("flush2.clear_c", rob_clear, 1);
    cyc("flush2.d", 0, 0, 0, 0, 0, 0);
    chk("flush2.clear_d", rob_clear, 0);
    cyc("flush3.a", 1, 1, 0, 0, 1, 0);
    do_reset(1'b1);

    // Randomized traffic in alternating fill/empty-biased phases.
    dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 150) % 2 == 0) ? 80 : 30;
      q0 = ($urandom_range(0, 99) < bias);
      q1 = ($urandom_range(0, 99) < bias);
      t0 = ($urandom_range(0, 99) < 110 - bias);
      t1 = ($urandom_range(0, 99) < 110 - bias);
      fl = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      cyc("rand", q0, q1, t0, t1, fl, dr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
